draw_layer_arbiter: RTL and testbench
=====================================

Name: draw_layer_arbiter

Overview:
- Per-pixel compositor and collision scheduler between the object bitmap modules (level bitmaps, player sprite, enemies) and the VGA output.
- Each cycle it selects the highest-priority layer asserting drawingRequest and registers its RGB.
- It accumulates per-frame collisions between the player layer and every other layer, then reports them once per frame at startOfFrame for the game controller.

Parameters:
- NUM_LAYERS, 4, number of drawing requesters; index 0 is highest priority; legal range 2..8.
- PLAYER_LAYER, 0, index of the player sprite layer used for collision detection.
- BACKGROUND_RGB, 8'h00, colour output when no layer requests.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
- drawingRequest  in  NUM_LAYERS  per-layer draw request, already aligned with rgbIn.
- rgbIn  in  NUM_LAYERS x 8  per-layer RGB332 colour.
- playerHitEdgeCode  in  4  {Left,Top,Right,Bottom} edge code from the player bitmap, aligned with rgbIn.
- RGBOut  out  8  composited pixel colour.
- collisionValid  out  1  one-cycle pulse: last frame had at least one collision.
- collisionLayers  out  NUM_LAYERS  layers that overlapped the player during the reported frame; player bit always 0.
- collisionEdges  out  4  OR of playerHitEdgeCode over all colliding pixels of the reported frame.

Behaviour:
- Reset (async, resetN=0):
  - RGBOut=BACKGROUND_RGB; collisionValid=0; collisionLayers=0; collisionEdges=0.
  - Accumulators cleared; FSM to WAIT_SOF.
- Compositing, fixed latency 1 cycle:
  - RGBOut(t+1) = rgbIn[i](t) for the lowest i with drawingRequest[i]=1.
  - If no layer requests, RGBOut(t+1) = BACKGROUND_RGB.
  - Compositing runs in every FSM state.
- Collision pixel: drawingRequest[PLAYER_LAYER]=1 and any other bit of drawingRequest=1 in the same cycle.
  - In ACCUM, layerAcc |= (drawingRequest with player bit masked).
  - In ACCUM, edgeAcc |= playerHitEdgeCode.
- FSM states: WAIT_SOF, ACCUM, REPORT.
  - WAIT_SOF: accumulation disabled. startOfFrame -> ACCUM with accumulators cleared. Discards the partial frame after reset.
  - ACCUM: accumulates. On startOfFrame:
    - next-cycle outputs: collisionLayers=layerAcc, collisionEdges=edgeAcc, collisionValid = (layerAcc!=0), all including the current cycle's contribution.
    - accumulators restart from 0; the current cycle's pixel counts only toward the closing frame.
    - go to REPORT.
  - REPORT: one cycle. collisionValid deasserts afterward. collisionLayers/collisionEdges hold until the next report. Accumulates the current pixel like ACCUM -> ACCUM.
  - startOfFrame during REPORT: treated as in ACCUM (an immediate second report). Not expected under VGA timing.
- collisionLayers and collisionEdges update only at a report, including when collisionValid=0 (both then report 0).
- resetN deassertion mid-frame: no report until one full frame has elapsed.
- All registers are plain flops; no combinational path from inputs to outputs.

Optional Feature:
- Macro: DRAW_ARB_DEBUG_EN.
- Defined: on a collision pixel, RGBOut(t+1)=8'hE0 (red) regardless of priority, for on-screen collision debugging.
- Undefined: normal priority compositing only; debug mux absent.

Decomposition:
- Shared package draw_pkg holds:
  - typedef rgb_t (logic [7:0]);
  - typedef hit_edge_t (logic [3:0], {Left,Top,Right,Bottom});
  - constants TRANSPARENT_ENCODING=8'hFF and DEBUG_COLLISION_RGB=8'hE0;
  - enum arb_state_t {WAIT_SOF, ACCUM, REPORT}.
- One sub-module, draw_priority_select: combinational priority encoder producing the selected index, any-request flag and collision flag. Top-level holds the registers and FSM.

Test Plan:
- Reset then single request: drawingRequest=4'b0100, rgbIn[2]=8'h1C -> RGBOut=8'h1C one cycle later. Requests 4'b0000 -> RGBOut=8'h00.
- Priority: drawingRequest=4'b0110, rgbIn[1]=8'hE3, rgbIn[2]=8'h1C -> RGBOut=8'hE3.
- Collision report:
  - After the first SOF, two pixels with drawingRequest=4'b0011; edges 4'b1000 then 4'b0001; next SOF.
  - Expected one cycle later: collisionValid=1 for one cycle, collisionLayers=4'b0010, collisionEdges=4'b1001.
- Clean frame: next frame has no overlap -> at SOF collisionValid=0, collisionLayers=0, collisionEdges=0.
- Reset mid-frame: inject overlap right after resetN rises, before the first SOF -> first SOF gives no pulse; overlap is not counted.
- DRAW_ARB_DEBUG_EN: overlap pixel with drawingRequest=4'b0011 -> RGBOut=8'hE0. Without the macro -> rgbIn[0].

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types and constants for the draw layer arbiter.
// Pixel colours are RGB332. Hit edges are ordered {Left,Top,Right,Bottom}.
package draw_pkg;

   typedef logic [7:0] rgb_t;
   typedef logic [3:0] hit_edge_t;

   localparam rgb_t TRANSPARENT_ENCODING = 8'hFF;
   localparam rgb_t DEBUG_COLLISION_RGB  = 8'hE0;

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      ACCUM    = 2'd1,
      REPORT   = 2'd2
   } arb_state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/draw_priority_select.sv
// Combinational priority encoder over the layer draw requests.
// Index 0 wins; it also flags player/other-layer overlap.
module draw_priority_select
   import draw_pkg::*;
#(
   parameter int NUM_LAYERS   = 4,
   parameter int PLAYER_LAYER = 0,
   parameter int IDX_W        = idx_w(NUM_LAYERS)
) (
   input  logic [NUM_LAYERS-1:0] req_i,
   output logic [IDX_W-1:0]      sel_o,
   output logic                  any_o,
   output logic                  collision_o
);

   localparam logic [NUM_LAYERS-1:0] PLAYER_MASK =
      NUM_LAYERS'(1) << PLAYER_LAYER;

   always_comb begin
      sel_o = '0;
      // Scan downwards so the lowest requesting index is kept last.
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            sel_o = IDX_W'(i);
         end
      end
   end

   assign any_o       = |req_i;
   assign collision_o = req_i[PLAYER_LAYER] &&
                        (|(req_i & ~PLAYER_MASK));

endmodule

// File: rtl/draw_layer_arbiter.sv
// Per-pixel compositor plus per-frame player collision reporter.
// Define DRAW_ARB_DEBUG_EN to paint collision pixels red.
module draw_layer_arbiter
   import draw_pkg::*;
#(
   parameter int   NUM_LAYERS     = 4,
   parameter int   PLAYER_LAYER   = 0,
   parameter rgb_t BACKGROUND_RGB = 8'h00
) (
   input  logic                       clk,
   input  logic                       resetN,
   input  logic                       startOfFrame,
   input  logic [NUM_LAYERS-1:0]      drawingRequest,
   input  logic [NUM_LAYERS-1:0][7:0] rgbIn,
   input  hit_edge_t                  playerHitEdgeCode,
   output rgb_t                       RGBOut,
   output logic                       collisionValid,
   output logic [NUM_LAYERS-1:0]      collisionLayers,
   output hit_edge_t                  collisionEdges
);

   localparam int IDX_W = idx_w(NUM_LAYERS);
   localparam logic [NUM_LAYERS-1:0] PLAYER_MASK =
      NUM_LAYERS'(1) << PLAYER_LAYER;

   logic [IDX_W-1:0] sel;
   logic             any_req;
   logic             collision;

   draw_priority_select #(
      .NUM_LAYERS   (NUM_LAYERS),
      .PLAYER_LAYER (PLAYER_LAYER),
      .IDX_W        (IDX_W)
   ) u_sel (
      .req_i       (drawingRequest),
      .sel_o       (sel),
      .any_o       (any_req),
      .collision_o (collision)
   );

   rgb_t                  rgb_q, rgb_d;
   arb_state_t            state_q, state_d;
   logic [NUM_LAYERS-1:0] layer_acc_q, layer_acc_d;
   hit_edge_t             edge_acc_q, edge_acc_d;
   logic                  valid_q, valid_d;
   logic [NUM_LAYERS-1:0] layers_q, layers_d;
   hit_edge_t             edges_q, edges_d;

   logic [NUM_LAYERS-1:0] hit_layers;
   hit_edge_t             hit_edges;

   always_comb begin
      rgb_d = any_req ? rgb_t'(rgbIn[sel]) : BACKGROUND_RGB;
`ifdef DRAW_ARB_DEBUG_EN
      if (collision) begin
         rgb_d = DEBUG_COLLISION_RGB;
      end
`endif
   end

   assign hit_layers = collision ? (drawingRequest & ~PLAYER_MASK) : '0;
   assign hit_edges  = collision ? playerHitEdgeCode : '0;

   always_comb begin
      state_d     = state_q;
      layer_acc_d = layer_acc_q;
      edge_acc_d  = edge_acc_q;
      valid_d     = 1'b0;
      layers_d    = layers_q;
      edges_d     = edges_q;
      case (state_q)
         WAIT_SOF: begin
            // Partial frame after reset is discarded.
            if (startOfFrame) begin
               state_d     = ACCUM;
               layer_acc_d = '0;
               edge_acc_d  = '0;
            end
         end
         ACCUM, REPORT: begin
            if (startOfFrame) begin
               layers_d    = layer_acc_q | hit_layers;
               edges_d     = edge_acc_q | hit_edges;
               valid_d     = |(layer_acc_q | hit_layers);
               layer_acc_d = '0;
               edge_acc_d  = '0;
               state_d     = REPORT;
            end else begin
               layer_acc_d = layer_acc_q | hit_layers;
               edge_acc_d  = edge_acc_q | hit_edges;
               state_d     = ACCUM;
            end
         end
         default: begin
            state_d = WAIT_SOF;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         rgb_q       <= BACKGROUND_RGB;
         state_q     <= WAIT_SOF;
         layer_acc_q <= '0;
         edge_acc_q  <= '0;
         valid_q     <= 1'b0;
         layers_q    <= '0;
         edges_q     <= '0;
      end else begin
         rgb_q       <= rgb_d;
         state_q     <= state_d;
         layer_acc_q <= layer_acc_d;
         edge_acc_q  <= edge_acc_d;
         valid_q     <= valid_d;
         layers_q    <= layers_d;
         edges_q     <= edges_d;
      end
   end

   assign RGBOut          = rgb_q;
   assign collisionValid  = valid_q;
   assign collisionLayers = layers_q;
   assign collisionEdges  = edges_q;

endmodule

// File: tb/tb_draw_layer_arbiter.sv
// Directed bench for draw_layer_arbiter (default 4 layers, player 0).
// Expected colours follow DRAW_ARB_DEBUG_EN when it is defined.
module tb_draw_layer_arbiter;

   logic            clk = 1'b0;
   logic            resetN;
   logic            sof;
   logic [3:0]      req;
   logic [3:0][7:0] rgb;
   logic [3:0]      edge_code;
   logic [7:0]      rgb_out;
   logic            cvalid;
   logic [3:0]      clayers;
   logic [3:0]      cedges;

   int nvec = 0;
   int nerr = 0;

`ifdef DRAW_ARB_DEBUG_EN
   localparam logic [7:0] OVL_RGB = 8'hE0;
`else
   localparam logic [7:0] OVL_RGB = 8'h55;
`endif

   always #5 clk = ~clk;

   draw_layer_arbiter dut (
      .clk               (clk),
      .resetN            (resetN),
      .startOfFrame      (sof),
      .drawingRequest    (req),
      .rgbIn             (rgb),
      .playerHitEdgeCode (edge_code),
      .RGBOut            (rgb_out),
      .collisionValid    (cvalid),
      .collisionLayers   (clayers),
      .collisionEdges    (cedges)
   );

   task automatic check(input string tag,
                        input logic [7:0] obs,
                        input logic [7:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic s,
                        input logic [3:0] r,
                        input logic [3:0] e);
      sof       = s;
      req       = r;
      edge_code = e;
      @(posedge clk);
      #1;
   endtask

   task automatic check_rep(input string tag,
                            input logic v,
                            input logic [3:0] l,
                            input logic [3:0] e);
      check({tag, "_valid"}, {7'd0, cvalid}, {7'd0, v});
      check({tag, "_layers"}, {4'd0, clayers}, {4'd0, l});
      check({tag, "_edges"}, {4'd0, cedges}, {4'd0, e});
   endtask

   initial begin
      resetN    = 1'b0;
      sof       = 1'b0;
      req       = 4'b0000;
      edge_code = 4'b0000;
      rgb[0]    = 8'h55;
      rgb[1]    = 8'hE3;
      rgb[2]    = 8'h1C;
      rgb[3]    = 8'h03;
      #1;
      check("rst_rgb", rgb_out, 8'h00);
      check_rep("rst", 1'b0, 4'b0000, 4'b0000);
      @(posedge clk);
      @(posedge clk);
      #1;
      resetN = 1'b1;

      // overlap before the first SOF must be discarded
      drive(1'b0, 4'b0011, 4'b1111);
      check("pre_sof_rgb", rgb_out, OVL_RGB);
      drive(1'b1, 4'b0000, 4'b0000);
      check("first_sof_rgb", rgb_out, 8'h00);
      check_rep("first_sof", 1'b0, 4'b0000, 4'b0000);

      drive(1'b0, 4'b0100, 4'b0000);
      check("single", rgb_out, 8'h1C);
      drive(1'b0, 4'b0000, 4'b0000);
      check("none", rgb_out, 8'h00);
      drive(1'b0, 4'b0110, 4'b0000);
      check("prio", rgb_out, 8'hE3);
      drive(1'b0, 4'b1000, 4'b0000);
      check("low", rgb_out, 8'h03);

      drive(1'b0, 4'b0011, 4'b1000);
      check("ovl1_rgb", rgb_out, OVL_RGB);
      drive(1'b0, 4'b0011, 4'b0001);
      check("ovl2_rgb", rgb_out, OVL_RGB);
      drive(1'b0, 4'b0001, 4'b0110);
      check("player_only", rgb_out, 8'h55);
      drive(1'b1, 4'b0000, 4'b0000);
      check_rep("rep1", 1'b1, 4'b0010, 4'b1001);
      drive(1'b0, 4'b0000, 4'b0000);
      check_rep("rep1_hold", 1'b0, 4'b0010, 4'b1001);

      // clean frame
      drive(1'b0, 4'b0100, 4'b0010);
      drive(1'b0, 4'b1010, 4'b0010);
      drive(1'b1, 4'b0000, 4'b0000);
      check_rep("clean", 1'b0, 4'b0000, 4'b0000);

      // pixel on the SOF cycle belongs to the closing frame
      drive(1'b0, 4'b0000, 4'b0000);
      drive(1'b1, 4'b0101, 4'b0100);
      check("sof_ovl_rgb", rgb_out, OVL_RGB);
      check_rep("sof_pix", 1'b1, 4'b0100, 4'b0100);
      drive(1'b0, 4'b0000, 4'b0000);
      check("sof_pix_pulse", {7'd0, cvalid}, 8'd0);
      drive(1'b1, 4'b0000, 4'b0000);
      check_rep("after_sof_pix", 1'b0, 4'b0000, 4'b0000);

      // overlap in the REPORT cycle counts toward the new frame
      drive(1'b0, 4'b1001, 4'b0010);
      drive(1'b1, 4'b0000, 4'b0000);
      check_rep("rep_cycle_acc", 1'b1, 4'b1000, 4'b0010);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
